// File: rtl/burst_packer_pkg.sv
// Shared types and width helpers for the AXI-Stream burst packer.
// Imported by burst_packer_fifo and axis_burst_packer.
package burst_packer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        PAD
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

    function automatic int lvl_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic int bcnt_w(input int len);
        return (len > 1) ? clog2(len) : 1;
    endfunction

    localparam int DEF_FIFO_DEPTH = 32;
    localparam int DEF_BURST_LEN  = 16;
    localparam int LVL_W  = lvl_w(DEF_FIFO_DEPTH);
    localparam int BCNT_W = bcnt_w(DEF_BURST_LEN);

endpackage

// File: rtl/burst_packer_fifo.sv
// Synchronous FIFO with a registered read port; rd_data updates
// the cycle after rd_en and holds otherwise.
module burst_packer_fifo
    import burst_packer_pkg::*;
#(
    parameter int DW    = 64,
    parameter int DEPTH = 32,
    localparam int AW   = clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge aclk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem_q[rd_ptr_q];
            end
            unique case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign rd_data = rd_data_q;
    assign level   = level_q;
    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);

endmodule

// File: rtl/axis_burst_packer.sv
// Releases an AXI-Stream in whole BURST_LEN bursts, padding frame tails.
// Define BURST_PACKER_BYTE_SWAP_EN to byte-reverse real output beats.
module axis_burst_packer
    import burst_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] PAD_WORD = '0,
    localparam int LW = lvl_w(FIFO_DEPTH),
    localparam int BW = bcnt_w(BURST_LEN)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  burst_done,
    output logic                  frame_done,
    output logic [7:0]            pad_cnt,
    output logic [LW-1:0]         level
);

    localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [BW-1:0]   fcnt_q, fcnt_d;
    logic [BW-1:0]   rem_q, rem_d;
    logic [BW-1:0]   fnext;
    logic            closing_q, closing_d;
    logic            rdy_q;
    logic [7:0]      pad_q, pad_d;
    logic            push, rd_en, end_burst;
    logic            fifo_full, fifo_empty;
    logic [LW-1:0]   fifo_lvl;
    logic [DATA_WIDTH-1:0] rd_data, beat_data;

    burst_packer_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .areset  (areset),
        .wr_en   (push),
        .wr_data (s_tdata),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_lvl)
    );

`ifdef BURST_PACKER_BYTE_SWAP_EN
    always_comb begin
        beat_data = '0;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            beat_data[8*i +: 8] = rd_data[DATA_WIDTH-8-8*i +: 8];
        end
    end
`else
    assign beat_data = rd_data;
`endif

    // The prefetched beat in the read register still counts as buffered.
    assign level    = fifo_lvl + LW'(state_q == SEND);
    assign s_tready = rdy_q && !closing_q && !fifo_full
                      && (level != LW'(FIFO_DEPTH));
    assign push     = s_tvalid && s_tready;
    assign fnext    = (fcnt_q == LAST) ? '0 : fcnt_q + 1'b1;
    assign pad_cnt  = pad_q;

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        fcnt_d     = fcnt_q;
        rem_d      = rem_q;
        closing_d  = closing_q;
        pad_d      = pad_q;
        rd_en      = 1'b0;
        end_burst  = 1'b0;
        m_tvalid   = 1'b0;
        m_tlast    = 1'b0;
        m_tdata    = '0;
        burst_done = 1'b0;
        frame_done = 1'b0;

        if (push) begin
            if (s_tlast) begin
                rem_d     = fnext;
                fcnt_d    = '0;
                closing_d = 1'b1;
            end else begin
                fcnt_d = fnext;
            end
        end

        unique case (state_q)
            IDLE: begin
                bcnt_d = '0;
                if (fifo_lvl >= LW'(BURST_LEN)) begin
                    state_d = LOAD;
                end else if (closing_q && !fifo_empty) begin
                    state_d = LOAD;
                end else if (closing_q) begin
                    closing_d  = 1'b0;
                    frame_done = 1'b1;
                    pad_d      = '0;
                end
            end
            LOAD: begin
                rd_en   = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                m_tvalid = 1'b1;
                m_tdata  = beat_data;
                m_tlast  = (bcnt_q == LAST);
                if (m_tready) begin
                    if (bcnt_q == LAST) begin
                        end_burst = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                        if (!fifo_empty) rd_en = 1'b1;
                        else state_d = PAD;
                    end
                end
            end
            PAD: begin
                m_tvalid = 1'b1;
                m_tdata  = PAD_WORD;
                m_tlast  = (bcnt_q == LAST);
                if (m_tready) begin
                    if (bcnt_q == LAST) end_burst = 1'b1;
                    else bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A closing frame ends when its last burst leaves nothing behind.
        if (end_burst) begin
            burst_done = 1'b1;
            state_d    = IDLE;
            if (closing_q && fifo_empty) begin
                frame_done = 1'b1;
                closing_d  = 1'b0;
                pad_d      = (rem_q == '0) ? 8'd0
                             : 8'(BURST_LEN - int'(rem_q));
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            bcnt_q    <= '0;
            fcnt_q    <= '0;
            rem_q     <= '0;
            closing_q <= 1'b0;
            pad_q     <= '0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            fcnt_q    <= fcnt_d;
            rem_q     <= rem_d;
            closing_q <= closing_d;
            pad_q     <= pad_d;
            rdy_q     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_burst_packer.sv
// Randomized bench for axis_burst_packer against a frame/queue model
// of the expected output stream (data, padding, burst and frame marks).
module tb_axis_burst_packer;

    localparam int DW    = 64;
    localparam int BL    = 16;
    localparam int DEPTH = 32;
    localparam logic [DW-1:0] PADW = 64'hA5A5_0000_5A5A_FFFF;

    logic          aclk;
    logic          areset;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic          burst_done;
    logic          frame_done;
    logic [7:0]    pad_cnt;
    logic [5:0]    level;

    axis_burst_packer #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (DEPTH),
        .PAD_WORD   (PADW)
    ) u_dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .burst_done (burst_done),
        .frame_done (frame_done),
        .pad_cnt    (pad_cnt),
        .level      (level)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] d;
        bit            fd;
    } ent_t;

    ent_t        expq[$];
    int          padq[$];
    ent_t        e;
    int          fbeats      = 0;
    int          out_cnt     = 0;
    int          frames_done = 0;
    int          frames_sent = 0;
    bit          pend_pad    = 0;
    int          pend_val    = 0;
    bit          stall_q     = 0;
    logic [DW-1:0] stall_d   = '0;
    int          cyc         = 0;
    int          last_end    = -1;
    bit          gap_en      = 0;
    int          rdy_mode    = 1;
    int          p;

    function automatic logic [DW-1:0] xform(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
`ifdef BURST_PACKER_BYTE_SWAP_EN
        for (int i = 0; i < DW / 8; i++) r[8*i +: 8] = d[DW-8-8*i +: 8];
`endif
        return r;
    endfunction

    always @(negedge aclk) begin
        cyc++;
        if (areset) begin
            expq.delete();
            padq.delete();
            fbeats   = 0;
            out_cnt  = 0;
            pend_pad = 0;
            stall_q  = 0;
        end else begin
            if (pend_pad) begin
                chk("pad_cnt", pad_cnt, pend_val);
                pend_pad = 0;
            end
            if (stall_q) begin
                chk("hold_valid", m_tvalid, 1);
                chk("hold_data", m_tdata, stall_d);
            end
            if (out_cnt % BL != 0) chk("contig", m_tvalid, 1);
            if (m_tvalid && m_tready) begin
                if (expq.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("data", m_tdata, e.d);
                    chk("tlast", m_tlast, (out_cnt % BL) == BL - 1);
                    chk("bdone", burst_done, (out_cnt % BL) == BL - 1);
                    chk("fdone", frame_done, e.fd);
                    if (e.fd) begin
                        pend_pad = 1;
                        pend_val = padq.pop_front();
                        frames_done++;
                    end
                end
                if (gap_en && out_cnt % BL == 0 && last_end >= 0)
                    chk("gap", cyc - last_end - 1, 2);
                if (out_cnt % BL == BL - 1) last_end = cyc;
                out_cnt++;
            end else begin
                chk("idle_pulse", {burst_done, frame_done}, 0);
            end
            stall_q = m_tvalid && !m_tready;
            stall_d = m_tdata;
            if (s_tvalid && s_tready) begin
                fbeats++;
                expq.push_back('{xform(s_tdata), 1'b0});
                if (s_tlast) begin
                    p = (BL - fbeats % BL) % BL;
                    repeat (p) expq.push_back('{PADW, 1'b0});
                    expq[expq.size()-1].fd = 1'b1;
                    padq.push_back(p);
                    fbeats = 0;
                end
            end
        end
    end

    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic send(input logic [DW-1:0] d, input bit last);
        int n;
        n = 0;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_tready && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        chk("send_ready", s_tready, 1);
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (last) frames_sent++;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || m_tvalid) && n < 5000) begin
            @(posedge aclk);
            n++;
        end
        chk("drain", expq.size(), 0);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    initial begin
        int len;
        int base;
        int n;
        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tready", s_tready, 0);
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_mdata", m_tdata, 0);
        chk("rst_mlast", m_tlast, 0);
        chk("rst_level", level, 0);
        chk("rst_pad", pad_cnt, 0);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        chk("rel_tready", s_tready, 1);

        // one exact burst, latency from the last accept
        for (int i = 1; i <= 16; i++) send(DW'(i), i == 16);
        chk("lat_e1", m_tvalid, 0);
        @(posedge aclk);
        #1;
        chk("lat_e2", m_tvalid, 0);
        @(posedge aclk);
        #1;
        chk("lat_e3", m_tvalid, 1);
        wait_drain();

        // 20-beat frame: second burst padded with 12 words
        for (int i = 1; i <= 20; i++) send({$urandom, $urandom}, i == 20);
        wait_drain();

        // fill while the writer is stalled
        rdy_mode = 0;
        for (int i = 0; i < 32; i++) send({$urandom, $urandom}, 1'b0);
        @(negedge aclk);
        chk("full_tready", s_tready, 0);
        chk("full_level", level, 32);
        gap_en   = 1;
        last_end = -1;
        rdy_mode = 1;
        wait_drain();
        gap_en = 0;
        send({$urandom, $urandom}, 1'b1);
        wait_drain();

        // random frames with writer stalls and source gaps
        rdy_mode = 2;
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(1, 40);
            for (int b = 0; b < len; b++) begin
                send({$urandom, $urandom}, b == len - 1);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge aclk);
                    #1;
                end
            end
        end
        wait_drain();

        // reset in the middle of a burst
        rdy_mode = 1;
        base = out_cnt;
        for (int i = 0; i < 16; i++) send({$urandom, $urandom}, i == 15);
        frames_sent--;
        n = 0;
        while (out_cnt - base < 7 && n < 200) begin
            @(posedge aclk);
            n++;
        end
        chk("mid_reach", out_cnt - base >= 7, 1);
        #2;
        areset = 1'b1;
        #1;
        chk("mid_rst_valid", m_tvalid, 0);
        chk("mid_rst_level", level, 0);
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        @(posedge aclk);
        #1;
        for (int i = 1; i <= 16; i++) send(DW'(i * 3), i == 16);
        wait_drain();

        // single-beat frame, swap pattern
        send(64'h0102030405060708, 1'b1);
        wait_drain();

        chk("frames", frames_done, frames_sent);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
